controle_entrada: RTL and testbench

Input-conditioning stage directly upstream of the game datapath. Takes the five raw push-buttons and synchronizes and debounces each one. Produces the 2-bit direction levels controle_vertical/controle_horizontal and the confirma level that the datapath edge-detects. Optional hold-to-repeat makes a held direction key re-trigger the datapath's edge detectors, so the drone keeps moving or menu values keep stepping.

---
 rtl/controle_entrada.sv | 186 ++++++++++++++++++
 tb/tb_controle_entrada.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/controle_entrada.sv
// Button conditioning: 2-FF sync and debounce of five push-buttons, axis direction
// decode and optional hold-to-repeat axis FSMs (compile with `define AUTO_REPEAT_EN).
module controle_entrada #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botao_cima,
    input  logic       botao_baixo,
    input  logic       botao_esquerda,
    input  logic       botao_direita,
    input  logic       botao_confirma,
    output logic [1:0] controle_vertical,
    output logic [1:0] controle_horizontal,
    output logic       confirma,
    output logic       confirma_pulso,
    output logic [4:0] db_botoes
);

    localparam int unsigned NB     = 5;
    localparam int unsigned DBW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned I_CIMA = 0;
    localparam int unsigned I_BAIX = 1;
    localparam int unsigned I_ESQ  = 2;
    localparam int unsigned I_DIR  = 3;
    localparam int unsigned I_CONF = 4;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("controle_entrada: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    logic [NB-1:0]          w_raw;
    logic [NB-1:0]          r_sync1;
    logic [NB-1:0]          r_sync2;
    logic [NB-1:0]          r_stable;
    logic [NB-1:0]          w_stable_next;
    logic [NB-1:0][DBW-1:0] r_cnt;
    logic [NB-1:0][DBW-1:0] w_cnt_next;
    logic                   r_pulso;
    logic [1:0][1:0]        w_dir_nxt;

    assign w_raw = {botao_confirma, botao_direita, botao_esquerda, botao_baixo, botao_cima};

    // Opposing keys cancel; 11 can never be produced.
    function automatic logic [1:0] eixo(input logic soma, input logic sub);
        return {sub & ~soma, soma & ~sub};
    endfunction

    // Debounce: count consecutive mismatches, adopt the sync value on the last one.
    always_comb begin
        w_stable_next = r_stable;
        w_cnt_next    = '0;
        for (int i = 0; i < NB; i++) begin
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == DB_LAST) begin
                    w_stable_next[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
            r_pulso  <= 1'b0;
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_next;
            r_cnt    <= w_cnt_next;
            r_pulso  <= w_stable_next[I_CONF] & ~r_stable[I_CONF];
        end
    end

    // Axis logic looks at next-cycle stable values so outputs track db_botoes with no lag.
    assign w_dir_nxt[0] = eixo(w_stable_next[I_CIMA], w_stable_next[I_BAIX]);
    assign w_dir_nxt[1] = eixo(w_stable_next[I_DIR],  w_stable_next[I_ESQ]);

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(RMAX) + 1;
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TMAX        = '1;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ESPERA = 2'd1,
        REPETE = 2'd2,
        LACUNA = 2'd3
    } estado_t;

    logic [1:0][1:0] w_dir_cur;

    assign w_dir_cur[0] = eixo(r_stable[I_CIMA], r_stable[I_BAIX]);
    assign w_dir_cur[1] = eixo(r_stable[I_DIR],  r_stable[I_ESQ]);

    for (genvar g = 0; g < 2; g++) begin : g_eixo
        estado_t       r_estado;
        estado_t       w_estado_next;
        logic [TW-1:0] r_timer;
        logic [TW-1:0] w_timer_next;
        logic [1:0]    r_saida;
        logic [1:0]    w_saida_next;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_estado <= OCIOSO;
                r_timer  <= '0;
                r_saida  <= 2'b00;
            end else begin
                r_estado <= w_estado_next;
                r_timer  <= w_timer_next;
                r_saida  <= w_saida_next;
            end
        end

        // Release or direction change overrides the repeat timing.
        always_comb begin
            w_estado_next = r_estado;
            w_timer_next  = (r_timer == TMAX) ? r_timer : r_timer + TW'(1);
            w_saida_next  = w_dir_nxt[g];
            if (w_dir_nxt[g] == 2'b00) begin
                w_estado_next = OCIOSO;
                w_timer_next  = '0;
            end else if (r_estado == OCIOSO || w_dir_nxt[g] != w_dir_cur[g]) begin
                w_estado_next = ESPERA;
                w_timer_next  = '0;
            end else begin
                case (r_estado)
                    ESPERA: begin
                        if (r_timer == DELAY_LAST) begin
                            w_estado_next = LACUNA;
                            w_timer_next  = '0;
                        end
                    end
                    REPETE: begin
                        if (r_timer == PERIOD_LAST) begin
                            w_estado_next = LACUNA;
                            w_timer_next  = '0;
                        end
                    end
                    LACUNA: begin
                        w_estado_next = REPETE;
                        w_timer_next  = '0;
                    end
                    default: begin
                        w_estado_next = OCIOSO;
                        w_timer_next  = '0;
                    end
                endcase
            end
            if (w_estado_next == LACUNA) begin
                w_saida_next = 2'b00;
            end
        end
    end
`else
    for (genvar g = 0; g < 2; g++) begin : g_eixo
        logic [1:0] r_saida;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_saida <= 2'b00;
            end else begin
                r_saida <= w_dir_nxt[g];
            end
        end
    end
`endif

    assign controle_vertical   = g_eixo[0].r_saida;
    assign controle_horizontal = g_eixo[1].r_saida;
    assign confirma            = r_stable[I_CONF];
    assign confirma_pulso      = r_pulso;
    assign db_botoes           = r_stable;

endmodule

// File: tb/tb_controle_entrada.sv
// Directed bench for controle_entrada: debounce latency, glitch rejection, cancel rule,
// auto-repeat gaps (when AUTO_REPEAT_EN is defined), confirma pulse and async reset.
module tb_controle_entrada;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cima = 1'b0, baixo = 1'b0, esq = 1'b0, dir = 1'b0, conf = 1'b0;
    logic [1:0] vert, horiz;
    logic       confirma, pulso;
    logic [4:0] db;

    int checks = 0;
    int errors = 0;

    controle_entrada #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .botao_cima         (cima),
        .botao_baixo        (baixo),
        .botao_esquerda     (esq),
        .botao_direita      (dir),
        .botao_confirma     (conf),
        .controle_vertical  (vert),
        .controle_horizontal(horiz),
        .confirma           (confirma),
        .confirma_pulso     (pulso),
        .db_botoes          (db)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected axis output j cycles after a held direction first appeared.
    function automatic logic [1:0] rep(input logic [1:0] d, input int j);
        if (AUTO && j >= RD && ((j - RD) % (RP + 1)) == 0) return 2'b00;
        return d;
    endfunction

    initial begin
        // reset state
        tick(3);
        chk("rst_vert", 8'(vert), 8'h0);
        chk("rst_horiz", 8'(horiz), 8'h0);
        chk("rst_db", 8'(db), 8'h0);
        chk("rst_conf", 8'({confirma, pulso}), 8'h0);
        reset = 1'b1;
        tick(2);

        // 1: bounce on cima, then settle
        cima = 1'b1; tick(1); chk("bounce_a", 8'(vert), 8'h0);
        cima = 1'b0; tick(1); chk("bounce_b", 8'(vert), 8'h0);
        cima = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk("cima_lat", 8'(vert), (k < 6) ? 8'h0 : 8'h1);
        end
        cima = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk("cima_rel", 8'(vert), (k < 6) ? 8'h1 : 8'h0);
        end
        tick(3);

        // 2: direita held, repeat gaps, release
        dir = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("dir_pre", 8'(horiz), 8'h0);
        end
        for (int j = 0; j <= 62; j++) begin
            tick(1);
            chk("dir_hold", 8'(horiz), (j >= 60) ? 8'h0 : 8'(rep(2'b01, j)));
            if (j == 54) dir = 1'b0;
        end
        chk("dir_db", 8'(db), 8'h0);

        // 3: cima+baixo cancel, then release baixo
        cima = 1'b1; baixo = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            chk("cancel", 8'(vert), 8'h0);
        end
        chk("cancel_db", 8'(db), 8'h03);
        baixo = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("unc_pre", 8'(vert), 8'h0);
        end
        for (int j = 0; j <= 21; j++) begin
            tick(1);
            chk("unc_hold", 8'(vert), 8'(rep(2'b01, j)));
        end
        cima = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk("unc_rel", 8'(vert), (k < 6) ? 8'(rep(2'b01, 21 + k)) : 8'h0);
        end

        // 4: confirma 30 cycles, single pulse
        conf = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            chk("confirma", 8'({confirma, pulso}),
                8'({(k >= 6 && k < 36), (k == 6)}));
            if (k == 30) conf = 1'b0;
        end

        // glitch of DEBOUNCE_CYCLES-1 synchronized cycles is rejected
        esq = 1'b1; tick(3); esq = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk("glitch", 8'(horiz), 8'h0);
        end
        chk("glitch_db", 8'(db), 8'h0);

        // 5: async reset mid-ESPERA with esquerda held
        esq = 1'b1;
        for (int k = 1; k <= 6; k++) tick(1);
        chk("esq_on", 8'(horiz), 8'h2);
        tick(5);
        chk("esq_mid", 8'(horiz), 8'h2);
        reset = 1'b0;
        #2;
        chk("arst_horiz", 8'(horiz), 8'h0);
        chk("arst_db", 8'(db), 8'h0);
        tick(2);
        chk("arst_hold", 8'({vert, horiz, confirma, pulso}), 8'h0);
        reset = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            chk("esq_new", 8'(horiz), (k < 6) ? 8'h0 : 8'(rep(2'b10, k - 6)));
        end
        esq = 1'b0;
        tick(8);
        chk("esq_rel", 8'(horiz), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
